// File: rtl/pc_gen_unit.sv
// Fetch-PC generator: sequential advance, Execute redirects, stall buffering.
// Optional build macro PCGEN_PERF_CNT_EN enables the redirect counter.
module pc_gen_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_sel,
  input  logic [31:0]      pc_e,
  input  logic [31:0]      rs_val,
  input  logic [25:0]      target,
  input  logic [31:0]      ext_imm,
  output logic [31:0]      pc_f,
  output logic             pc_valid,
  output logic             redirect_pending,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_count
);

  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] br_tgt;
  logic [31:0] live_tgt;
  logic        live_mis;
  logic        live;
  logic [1:0]  unused_imm;

  logic [31:0] pc_q;
  logic        valid_q;
  logic        pend_q;
  logic [31:0] pend_tgt_q;
  logic        pend_mis_q;
  logic        mis_q;

  assign unused_imm = ext_imm[31:30];

  assign j_tgt  = {pc_e[31:28], target, 2'b00};
  assign jr_tgt = {rs_val[31:2], 2'b00};
  // Word offset: the two top immediate bits fall off the shift
  assign br_tgt = pc_e + 32'd4 + {ext_imm[29:0], 2'b00};

  assign live = redirect_valid && (redirect_sel != 2'b00);

  always_comb begin
    live_tgt = br_tgt;
    live_mis = 1'b0;
    case (redirect_sel)
      2'b01:   live_tgt = j_tgt;
      2'b10: begin
        live_tgt = jr_tgt;
        live_mis = |rs_val[1:0];
      end
      default: live_tgt = br_tgt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      mis_q   <= 1'b0;
      if (stall) begin
        if (live) begin
          pend_q     <= 1'b1;
          pend_tgt_q <= live_tgt;
          pend_mis_q <= live_mis;
        end
      end else if (live) begin
        pc_q   <= live_tgt;
        pend_q <= 1'b0;
        mis_q  <= live_mis;
      end else if (pend_q) begin
        pc_q   <= pend_tgt_q;
        pend_q <= 1'b0;
        mis_q  <= pend_mis_q;
      end else begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

`ifdef PCGEN_PERF_CNT_EN
  logic             apply;
  logic [CNT_W-1:0] cnt_q;

  assign apply = !stall && (live || pend_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (apply && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign redirect_count = cnt_q;
`else
  assign redirect_count = '0;
`endif

  assign pc_f             = pc_q;
  assign pc_valid         = valid_q;
  assign redirect_pending = pend_q;
  assign misalign         = mis_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: main instance plus a 2-bit counter
// instance sharing the same stimulus for the saturation check.
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] pc_e;
  logic [31:0] rs_val;
  logic [25:0] target;
  logic [31:0] ext_imm;
  logic [31:0] pc_f;
  logic        pc_valid;
  logic        redirect_pending;
  logic        misalign;
  logic [15:0] redirect_count;
  logic [31:0] pc_f2;
  logic        pc_valid2;
  logic        pend2;
  logic        mis2;
  logic [1:0]  cnt2;

  int total;
  int bad;
  int nred;

  pc_gen_unit #(
    .RESET_VEC(32'h0040_0000),
    .CNT_W    (16),
    .PC_STEP  (32'd4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .pc_e            (pc_e),
    .rs_val          (rs_val),
    .target          (target),
    .ext_imm         (ext_imm),
    .pc_f            (pc_f),
    .pc_valid        (pc_valid),
    .redirect_pending(redirect_pending),
    .misalign        (misalign),
    .redirect_count  (redirect_count)
  );

  pc_gen_unit #(
    .RESET_VEC(32'h0040_0000),
    .CNT_W    (2),
    .PC_STEP  (32'd4)
  ) dut2 (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .pc_e            (pc_e),
    .rs_val          (rs_val),
    .target          (target),
    .ext_imm         (ext_imm),
    .pc_f            (pc_f2),
    .pc_valid        (pc_valid2),
    .redirect_pending(pend2),
    .misalign        (mis2),
    .redirect_count  (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ec(int n, int w);
`ifdef PCGEN_PERF_CNT_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    redirect_valid = 1'b0;
    redirect_sel   = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    idle();
    tick();
    tick();
    total++;
    if (pc_f !== 32'h0040_0000) begin
      bad++;
      $display("FAIL rst_pc got=%h exp=%h", pc_f, 32'h0040_0000);
    end
    total++;
    if (pc_valid !== 1'b0 || redirect_pending !== 1'b0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b%b%b exp=000",
               pc_valid, redirect_pending, misalign);
    end
    total++;
    if (redirect_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d exp=0", redirect_count);
    end
    rst = 1'b0;
    tick();
    total++;
    if (pc_f !== 32'h0040_0004 || pc_valid !== 1'b1) begin
      bad++;
      $display("FAIL seq1 got=%h/%b exp=00400004/1", pc_f, pc_valid);
    end
    tick();
    total++;
    if (pc_f !== 32'h0040_0008) begin
      bad++;
      $display("FAIL seq2 got=%h exp=00400008", pc_f);
    end
  endtask

  task automatic test_branch();
    pc_e = 32'h0040_0010;
    ext_imm = 32'hFFFF_FFFE;
    redirect_sel = 2'b11;
    redirect_valid = 1'b1;
    tick();
    nred++;
    idle();
    total++;
    if (pc_f !== 32'h0040_000C) begin
      bad++;
      $display("FAIL branch got=%h exp=0040000c", pc_f);
    end
    total++;
    if (redirect_count !== 16'(ec(nred, 16))) begin
      bad++;
      $display("FAIL branch_cnt got=%0d exp=%0d", redirect_count, ec(nred, 16));
    end
    tick();
    total++;
    if (pc_f !== 32'h0040_0010) begin
      bad++;
      $display("FAIL branch_seq got=%h exp=00400010", pc_f);
    end
  endtask

  task automatic test_jump();
    pc_e = 32'h0040_0020;
    target = 26'h010_0040;
    redirect_sel = 2'b01;
    redirect_valid = 1'b1;
    tick();
    nred++;
    idle();
    total++;
    if (pc_f !== 32'h0040_0100 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL jump got=%h/%b exp=00400100/0", pc_f, misalign);
    end
  endtask

  task automatic test_misalign();
    rs_val = 32'h0040_0203;
    redirect_sel = 2'b10;
    redirect_valid = 1'b1;
    tick();
    nred++;
    idle();
    total++;
    if (pc_f !== 32'h0040_0200 || misalign !== 1'b1) begin
      bad++;
      $display("FAIL jr_mis got=%h/%b exp=00400200/1", pc_f, misalign);
    end
    tick();
    total++;
    if (pc_f !== 32'h0040_0204 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL jr_mis_end got=%h/%b exp=00400204/0", pc_f, misalign);
    end
    total++;
    if (redirect_count !== 16'(ec(nred, 16))) begin
      bad++;
      $display("FAIL jr_cnt got=%0d exp=%0d", redirect_count, ec(nred, 16));
    end
  endtask

  task automatic test_sel_zero();
    redirect_sel = 2'b00;
    redirect_valid = 1'b1;
    tick();
    idle();
    total++;
    if (pc_f !== 32'h0040_0208 || redirect_count !== 16'(ec(nred, 16))) begin
      bad++;
      $display("FAIL sel00 got=%h/%0d exp=00400208/%0d",
               pc_f, redirect_count, ec(nred, 16));
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    pc_e = 32'h0000_0FFC;
    ext_imm = 32'h0;
    redirect_sel = 2'b11;
    redirect_valid = 1'b1;
    tick();
    pc_e = 32'h0000_0000;
    target = 26'h000_0800;
    redirect_sel = 2'b01;
    tick();
    idle();
    tick();
    total++;
    if (pc_f !== 32'h0040_0208 || redirect_pending !== 1'b1) begin
      bad++;
      $display("FAIL stall_hold got=%h/%b exp=00400208/1", pc_f, redirect_pending);
    end
    stall = 1'b0;
    tick();
    nred++;
    total++;
    if (pc_f !== 32'h0000_2000 || redirect_pending !== 1'b0) begin
      bad++;
      $display("FAIL stall_rel got=%h/%b exp=00002000/0", pc_f, redirect_pending);
    end
    total++;
    if (redirect_count !== 16'(ec(nred, 16))) begin
      bad++;
      $display("FAIL stall_cnt got=%0d exp=%0d", redirect_count, ec(nred, 16));
    end
    tick();
    total++;
    if (pc_f !== 32'h0000_2004) begin
      bad++;
      $display("FAIL stall_seq got=%h exp=00002004", pc_f);
    end
  endtask

  task automatic test_stall_jr();
    stall = 1'b1;
    rs_val = 32'h0000_3001;
    redirect_sel = 2'b10;
    redirect_valid = 1'b1;
    tick();
    idle();
    total++;
    if (misalign !== 1'b0 || redirect_pending !== 1'b1 || pc_f !== 32'h0000_2004) begin
      bad++;
      $display("FAIL sjr_hold got=%h/%b/%b exp=00002004/0/1",
               pc_f, misalign, redirect_pending);
    end
    stall = 1'b0;
    tick();
    nred++;
    total++;
    if (pc_f !== 32'h0000_3000 || misalign !== 1'b1) begin
      bad++;
      $display("FAIL sjr_rel got=%h/%b exp=00003000/1", pc_f, misalign);
    end
    tick();
    total++;
    if (misalign !== 1'b0) begin
      bad++;
      $display("FAIL sjr_pulse got=%b exp=0", misalign);
    end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1;
    pc_e = 32'h0;
    target = 26'h000_0800;
    redirect_sel = 2'b01;
    redirect_valid = 1'b1;
    tick();
    stall = 1'b0;
    pc_e = 32'h0000_0100;
    ext_imm = 32'h0000_0001;
    redirect_sel = 2'b11;
    tick();
    nred++;
    idle();
    total++;
    if (pc_f !== 32'h0000_0108 || redirect_pending !== 1'b0) begin
      bad++;
      $display("FAIL live_prio got=%h/%b exp=00000108/0", pc_f, redirect_pending);
    end
    tick();
    total++;
    if (pc_f !== 32'h0000_010C || redirect_count !== 16'(ec(nred, 16))) begin
      bad++;
      $display("FAIL live_prio2 got=%h/%0d exp=0000010c/%0d",
               pc_f, redirect_count, ec(nred, 16));
    end
  endtask

  task automatic test_wrap();
    pc_e = 32'hF000_0000;
    target = 26'h3FF_FFFF;
    redirect_sel = 2'b01;
    redirect_valid = 1'b1;
    tick();
    nred++;
    idle();
    total++;
    if (pc_f !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_set got=%h exp=fffffffc", pc_f);
    end
    tick();
    total++;
    if (pc_f !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap got=%h exp=00000000", pc_f);
    end
  endtask

  task automatic test_saturate();
    total++;
    if (cnt2 !== 2'(ec(nred, 2))) begin
      bad++;
      $display("FAIL sat got=%0d exp=%0d", cnt2, ec(nred, 2));
    end
    total++;
    if (redirect_count !== 16'(ec(nred, 16))) begin
      bad++;
      $display("FAIL cnt16 got=%0d exp=%0d", redirect_count, ec(nred, 16));
    end
  endtask

  task automatic test_rst_discard();
    stall = 1'b1;
    pc_e = 32'h0;
    target = 26'h000_0800;
    redirect_sel = 2'b01;
    redirect_valid = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    tick();
    total++;
    if (pc_f !== 32'h0040_0000 || redirect_pending !== 1'b0 || pc_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%h/%b/%b exp=00400000/0/0",
               pc_f, redirect_pending, pc_valid);
    end
    total++;
    if (redirect_count !== 16'd0 || cnt2 !== 2'd0) begin
      bad++;
      $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", redirect_count, cnt2);
    end
    rst = 1'b0;
    stall = 1'b0;
    tick();
    total++;
    if (pc_f !== 32'h0040_0004) begin
      bad++;
      $display("FAIL rst_drop got=%h exp=00400004", pc_f);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    nred = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel = 2'b00;
    pc_e = '0;
    rs_val = '0;
    target = '0;
    ext_imm = '0;
    #1;
    test_reset();
    test_branch();
    test_jump();
    test_misalign();
    test_sel_zero();
    test_stall();
    test_stall_jr();
    test_back_to_back();
    test_wrap();
    test_saturate();
    test_rst_discard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Sequential fetch-PC generator for the 5-stage MIPS core. It holds the fetch PC register and advances it by 4 each cycle. It applies J/JAL, JR/JALR and taken-branch redirects resolved in Execute, and buffers any redirect that arrives while fetch is stalled. It sits between the hazard unit (stall), the Execute stage (redirect info) and the instruction memory address port.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 16, width of the redirect performance counter.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stall  input  1  hold pc_f (hazard unit / imem not ready)
redirect_valid  input  1  Execute has resolved a control transfer this cycle
redirect_sel  input  2  01 J/JAL, 10 JR/JALR, 11 taken branch; 00 ignored even if redirect_valid=1
pc_e  input  32  PC of the instruction in Execute
rs_val  input  32  forwarded R[rs] for JR/JALR
target  input  26  instr_index field for J/JAL
ext_imm  input  32  sign-extended branch immediate
pc_f  output  32  current fetch PC (registered)
pc_valid  output  1  pc_f is a legal fetch address (registered)
redirect_pending  output  1  a redirect is buffered, awaiting stall release
misalign  output  1  one-cycle pulse: applied JR/JALR target had bits [1:0] != 0
redirect_count  output  CNT_W  number of redirects applied to pc_f

Behaviour:
- Reset (rst=1 at a rising edge): pc_f=RESET_VEC, pc_valid=0, redirect_pending=0, pending target=0, misalign=0, redirect_count=0. rst overrides stall and redirect. rst asserted mid-stall discards any pending redirect.
- pc_valid goes to 1 on the first edge with rst=0 and stays 1 until the next reset.
- Target computation is combinational, with all arithmetic modulo 2^32:
  - J/JAL: {pc_e[31:28], target, 2'b00}
  - JR/JALR: {rs_val[31:2], 2'b00}; raw misalignment flag = |rs_val[1:0]
  - Branch: pc_e + 4 + (ext_imm << 2); the shift drops the upper 2 bits of ext_imm
- Live redirect = redirect_valid && redirect_sel != 00.
- Per edge, rst=0, stall=0, in priority order:
  1. Live redirect: pc_f <= live target. Clear pending. Increment counter. misalign <= raw flag (JR/JALR only).
  2. Else if redirect_pending: pc_f <= pending target. Clear pending. Increment counter. misalign <= stored flag.
  3. Else: pc_f <= pc_f + PC_STEP (wraps 32'hFFFF_FFFC -> 0). misalign <= 0.
- Per edge, rst=0, stall=1:
  - pc_f holds.
  - A live redirect writes the pending target and flag and sets redirect_pending=1. If a redirect is already pending, the newer one overwrites it.
  - misalign <= 0.
- Latency: a redirect presented in cycle N with stall=0 appears on pc_f in cycle N+1. A redirect presented while stalled appears on pc_f the cycle after the first non-stalled edge.
- redirect_count saturates at all-ones and does not wrap.
- misalign is a single-cycle pulse, asserted in the same cycle pc_f shows the aligned target.

Optional Feature:
PCGEN_PERF_CNT_EN: when defined, the redirect_count register and its saturating increment are built as described above. When undefined, no counter flops are instantiated and redirect_count is tied to 0. All other behaviour is identical in both builds.

Test Plan:
- Reset, RESET_VEC=32'h0040_0000: rst high 2 cycles, then low with no redirects -> pc_f = 0040_0000, then 0040_0004, then 0040_0008. pc_valid=0 during rst, 1 from the first post-reset edge.
- Branch: pc_e=0040_0010, ext_imm=32'hFFFF_FFFE, sel=11, valid for 1 cycle -> next pc_f=0040_000C. redirect_count increments by 1.
- Jump: pc_e=0040_0020, target=26'h010_0040, sel=01 -> pc_f=0040_0100.
- Misaligned JR: rs_val=0040_0203, sel=10 -> pc_f=0040_0200, with misalign high exactly 1 cycle.
- Redirect during stall: stall=1 for 3 cycles; branch redirect in stall cycle 1 to 0000_1000, then J redirect in stall cycle 2 to 0000_2000 -> pc_f holds and redirect_pending=1. After stall drops, pc_f=0000_2000, pending=0, and count increments by 1 only.
- Wrap and saturation: force pc_f=FFFF_FFFC -> next pc_f=0000_0000. With CNT_W=2 and 5 redirects -> redirect_count=3. Without PCGEN_PERF_CNT_EN -> redirect_count=0.
